// File: rtl/conv_window5_gen.sv
// conv_window5_gen
//   Raster-to-window generator for the 5x5 convolution datapath. The block
//   takes one 8-bit pixel per valid cycle in raster order and keeps the four
//   previous lines in line buffers. Each accepted pixel shifts one new
//   column into a 5x5 window register. A one-cycle strobe marks windows
//   whose centre is an interior pixel.
//
//   Optional feature: define CONV_WIN5_FRAME_CHECK_EN to build the
//   truncated-frame detector that drives frame_err_o.
//
// Parameters
//   IMG_WIDTH   pixels per line  (5..4095)
//   IMG_HEIGHT  lines per frame  (5..4095)
//
// Ports
//   clk          clock
//   rst_n        asynchronous active-low reset
//   pix_valid_i  pixel accepted this cycle
//   pix_data_i   pixel value
//   pix_sof_i    first pixel of frame (qualified by pix_valid_i)
//   win_valid_o  one-cycle strobe: window valid
//   win_data_o   5x5 window, tap (r,c) at [(r*5+c)*8 +: 8]
//   win_x_o      column of window centre
//   win_y_o      line of window centre
//   frame_err_o  one-cycle strobe: sof arrived before the previous frame ended
module conv_window5_gen #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         pix_valid_i,
    input  logic [7:0]   pix_data_i,
    input  logic         pix_sof_i,
    output logic         win_valid_o,
    output logic [199:0] win_data_o,
    output logic [11:0]  win_x_o,
    output logic [11:0]  win_y_o,
    output logic         frame_err_o
);

    localparam int          AW       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [11:0] COL_LAST = 12'(IMG_WIDTH - 1);
    localparam logic [11:0] ROW_LAST = 12'(IMG_HEIGHT - 1);

    logic [11:0]   col;
    logic [11:0]   row;
    logic [11:0]   cur_col;
    logic [11:0]   cur_row;
    logic [AW-1:0] idx;
    logic [7:0]    lb [4][IMG_WIDTH];
    logic [7:0]    win [5][5];
    logic [7:0]    new_col [5];

    // A sof pixel is placed at (0,0) whatever the counters say, so the
    // line-buffer index and all position decisions use the effective position.
    assign cur_col = pix_sof_i ? 12'd0 : col;
    assign cur_row = pix_sof_i ? 12'd0 : row;
    assign idx     = cur_col[AW-1:0];

    always_comb begin
        new_col[0] = lb[3][idx];
        new_col[1] = lb[2][idx];
        new_col[2] = lb[1][idx];
        new_col[3] = lb[0][idx];
        new_col[4] = pix_data_i;
    end

    // Line buffers carry no reset: stale lines are never exposed because the
    // strobe needs row >= 4, by which point every column has been rewritten.
    always_ff @(posedge clk) begin
        if (pix_valid_i) begin
            lb[3][idx] <= lb[2][idx];
            lb[2][idx] <= lb[1][idx];
            lb[1][idx] <= lb[0][idx];
            lb[0][idx] <= pix_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col         <= '0;
            row         <= '0;
            win_valid_o <= 1'b0;
            win_x_o     <= '0;
            win_y_o     <= '0;
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 5; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else begin
            win_valid_o <= 1'b0;
            if (pix_valid_i) begin
                if (cur_col == COL_LAST) begin
                    col <= '0;
                    row <= (cur_row == ROW_LAST) ? 12'd0 : cur_row + 12'd1;
                end else begin
                    col <= cur_col + 12'd1;
                    row <= cur_row;
                end
                for (int r = 0; r < 5; r++) begin
                    for (int c = 0; c < 4; c++) begin
                        win[r][c] <= win[r][c+1];
                    end
                    win[r][4] <= new_col[r];
                end
                win_valid_o <= (cur_col >= 12'd4) && (cur_row >= 12'd4);
                // Centre trails the incoming pixel by two columns and two lines;
                // for col < 4 this wraps, but those windows are never strobed.
                win_x_o     <= cur_col - 12'd2;
                win_y_o     <= cur_row - 12'd2;
            end
        end
    end

    always_comb begin
        win_data_o = '0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                win_data_o[(r*5+c)*8 +: 8] = win[r][c];
            end
        end
    end

`ifdef CONV_WIN5_FRAME_CHECK_EN
    // Uses the raw counters: a sof that is not at (0,0) means the previous
    // frame was cut short.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_o <= 1'b0;
        end else begin
            frame_err_o <= pix_valid_i && pix_sof_i &&
                           ((col != 12'd0) || (row != 12'd0));
        end
    end
`else
    assign frame_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_conv_window5_gen.sv
module tb_conv_window5_gen;

    localparam int W = 8;
    localparam int H = 6;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         pix_valid = 1'b0;
    logic [7:0]   pix_data = '0;
    logic         pix_sof = 1'b0;
    logic         win_valid;
    logic [199:0] win_data;
    logic [11:0]  win_x;
    logic [11:0]  win_y;
    logic         frame_err;

    conv_window5_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_valid_i (pix_valid),
        .pix_data_i  (pix_data),
        .pix_sof_i   (pix_sof),
        .win_valid_o (win_valid),
        .win_data_o  (win_data),
        .win_x_o     (win_x),
        .win_y_o     (win_y),
        .frame_err_o (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cx;
        int cy;
        int centre;
        int tap00;
        int tap44;
    } vec_t;

    typedef struct {
        logic [11:0]  x;
        logic [11:0]  y;
        logic [199:0] d;
    } strobe_t;

    vec_t    tbl [8];
    strobe_t sq [$];

    int errors = 0;
    int checks = 0;

    // Reference model: a frame image indexed by position plus the position
    // of the next pixel. Windows are read straight out of the image.
    logic [7:0]   img [H][W];
    int           mx, my;
    logic         exp_valid, exp_err;
    logic [11:0]  exp_x, exp_y;
    logic [199:0] exp_win;
    bit           win_known;

    task automatic chk(string name, logic [199:0] act, logic [199:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mx = 0; my = 0;
        exp_valid = 0; exp_err = 0;
        exp_x = '0; exp_y = '0; exp_win = '0;
        win_known = 1;
    endtask

    task automatic model_step(bit v, logic [7:0] d, bit s);
        exp_valid = 0;
        exp_err   = 0;
        if (!v) return;
        if (s) begin
`ifdef CONV_WIN5_FRAME_CHECK_EN
            exp_err = (mx != 0) || (my != 0);
`endif
            mx = 0; my = 0;
        end
        img[my][mx] = d;
        exp_valid = (mx >= 4) && (my >= 4);
        exp_x = 12'(mx - 2);
        exp_y = 12'(my - 2);
        win_known = exp_valid;
        if (exp_valid) begin
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++)
                    exp_win[(r*5+c)*8 +: 8] = img[my-4+r][mx-4+c];
        end
        mx++;
        if (mx == W) begin
            mx = 0;
            my = (my == H - 1) ? 0 : my + 1;
        end
    endtask

    task automatic check_outputs();
        chk("win_valid", 200'(win_valid), 200'(exp_valid));
        chk("frame_err", 200'(frame_err), 200'(exp_err));
        chk("win_x", 200'(win_x), 200'(exp_x));
        chk("win_y", 200'(win_y), 200'(exp_y));
        if (win_known) chk("win_data", win_data, exp_win);
        if (win_valid) sq.push_back('{x: win_x, y: win_y, d: win_data});
    endtask

    task automatic drive(bit v, logic [7:0] d, bit s);
        pix_valid = v; pix_data = d; pix_sof = s;
        model_step(v, d, s);
        @(posedge clk); #1;
        check_outputs();
    endtask

    task automatic send_frame(bit bubbles, bit first_sof);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (bubbles) begin
                    while ($urandom_range(0, 1) == 1)
                        drive(0, 8'($urandom), 1'($urandom));
                end
                drive(1, 8'(y * W + x), first_sof && x == 0 && y == 0);
            end
        end
    endtask

    task automatic check_strobes(string tag, int nframes);
        chk({tag, "_count"}, 200'(sq.size()), 200'(8 * nframes));
        for (int i = 0; i < sq.size() && i < 8 * nframes; i++) begin
            chk({tag, "_cx"}, 200'(sq[i].x), 200'(tbl[i % 8].cx));
            chk({tag, "_cy"}, 200'(sq[i].y), 200'(tbl[i % 8].cy));
            chk({tag, "_centre"}, 200'(sq[i].d[103:96]), 200'(tbl[i % 8].centre));
            chk({tag, "_tap00"}, 200'(sq[i].d[7:0]), 200'(tbl[i % 8].tap00));
            chk({tag, "_tap44"}, 200'(sq[i].d[199:192]), 200'(tbl[i % 8].tap44));
        end
        sq.delete();
    endtask

    initial begin
        tbl[0] = '{2, 2, 18, 0, 36};
        tbl[1] = '{3, 2, 19, 1, 37};
        tbl[2] = '{4, 2, 20, 2, 38};
        tbl[3] = '{5, 2, 21, 3, 39};
        tbl[4] = '{2, 3, 26, 8, 44};
        tbl[5] = '{3, 3, 27, 9, 45};
        tbl[6] = '{4, 3, 28, 10, 46};
        tbl[7] = '{5, 3, 29, 11, 47};

        // Reset held with random inputs, then released with no pixels.
        model_reset();
        for (int i = 0; i < 5; i++) begin
            pix_valid = 1'($urandom); pix_data = 8'($urandom); pix_sof = 1'($urandom);
            @(posedge clk); #1;
            check_outputs();
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) drive(0, 8'($urandom), 1'($urandom));
        sq.delete();

        // One continuous frame.
        send_frame(0, 1);
        check_strobes("cont", 1);

        // Same frame with bubbles; model checks data hold during bubbles.
        send_frame(1, 1);
        check_strobes("bubble", 1);

        // Two back-to-back frames, sof only on the first.
        send_frame(0, 1);
        send_frame(0, 0);
        check_strobes("b2b", 2);

        // Truncated frame: sof arrives at (3,2).
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < W; x++)
                if (y < 2 || x < 3) drive(1, 8'(y * W + x), 0);
        chk("pre_sof_strobes", 200'(sq.size()), 200'(0));
        send_frame(0, 1);
        check_strobes("restart", 1);

        // Reset pulsed while (5,3) is next, then a fresh frame without sof.
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < W; x++)
                if (y < 3 || x < 5) drive(1, 8'(y * W + x), 0);
        sq.delete();
        rst_n = 1'b0;
        model_reset();
        #3;
        check_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(0, 8'h00, 0);
        send_frame(0, 0);
        check_strobes("post_rst", 1);

        // Random pixels, bubbles and occasional sof against the model.
        for (int i = 0; i < 600; i++) begin
            bit v;
            v = ($urandom_range(0, 3) != 0);
            drive(v, 8'($urandom), v && ($urandom_range(0, 39) == 0));
        end
        sq.delete();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_window5_gen.md
# conv_window5_gen

Raster-to-window generator for the 5x5 convolution datapath. Accepts one 8-bit pixel per valid cycle in raster order, buffers four previous lines, and presents the full 5x5 neighbourhood of every interior pixel with a one-cycle valid strobe. The tap-weighting and summing mask stages sit downstream and consume its window bus and strobe.

## Interface
- IMG_WIDTH, 640, pixels per line (>= 5, <= 4095)
- IMG_HEIGHT, 480, lines per frame (>= 5, <= 4095)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- pix_valid_i  in  1  pixel accepted this cycle
- pix_data_i  in  8  pixel value
- pix_sof_i  in  1  first pixel of frame; qualified by pix_valid_i
- win_valid_o  out  1  one-cycle strobe, window updated and valid
- win_data_o  out  200  5x5 window; tap (r,c) at bits [(r*5+c)*8 +: 8], r=0 top row, c=0 left column, centre at [103:96]
- win_x_o  out  12  column of window centre
- win_y_o  out  12  line of window centre
- frame_err_o  out  1  one-cycle strobe, framing error (see Configuration)

## Operation
- Counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) give the position of the pixel being accepted.
- Cycles with pix_valid_i=0 change no state; pix_sof_i is ignored.
- Accepted pixel with pix_sof_i=1 is treated as (0,0) regardless of counter values.
- Counters advance per accepted pixel: col wraps to 0 at IMG_WIDTH-1 and row increments. After (IMG_WIDTH-1, IMG_HEIGHT-1) both wrap to 0, so the next pixel starts a new frame without needing sof.
- Four line buffers lb0..lb3, IMG_WIDTH x 8 each, read combinationally at index col. On acceptance, new window column (top to bottom) = {lb3[col], lb2[col], lb1[col], lb0[col], pix_data_i}. It enters window column c=4, and columns 1..4 shift to 0..3. Then lb3[col]<=lb2[col], lb2<=lb1, lb1<=lb0, lb0<=pix_data_i.
- win_valid_o is asserted for an accepted pixel with col>=4 and row>=4. win_x_o = col-2 and win_y_o = row-2.
- Windows at col<4 span the previous line's tail. They are never flagged valid.
- Only interior centres are emitted: x in [2, IMG_WIDTH-3], y in [2, IMG_HEIGHT-3]. Output is (IMG_WIDTH-4)*(IMG_HEIGHT-4) windows per frame. No border padding and no end-of-frame flush.
- win_data_o, win_x_o and win_y_o update on every accepted pixel. They hold between acceptances.

## Timing
- Reset values:
  - win_valid_o=0, win_data_o=0, win_x_o=0, win_y_o=0, frame_err_o=0.
  - col=0, row=0, window registers 0.
  - Line-buffer contents are not reset. They are unobservable because valid is gated by row>=4.
- Latency: the window registers update on the clock edge that accepts pixel (col,row). win_valid_o is high for exactly the following cycle, registered on that same edge.
- Back-to-back valid gives one window per cycle. Throughput is 1 pixel/clk and there is no backpressure.
- Reset mid-frame: counters return to 0 immediately. The next accepted pixel is (0,0). No valid is produced until row 4 of the new frame.
- sof on the pixel immediately after a natural wrap to (0,0) is legal and not an error.

## Configuration
- CONV_WIN5_FRAME_CHECK_EN defined: frame_err_o pulses for one cycle after an accepted pixel with pix_sof_i=1 while (col,row)!=(0,0), i.e. a truncated previous frame. The counters still restart at (0,0) for that pixel.
- Not defined: frame_err_o is tied to 0 and no check logic is built. Counter restart on sof is unchanged.

## Test plan
- Reset: hold rst_n=0 with random inputs -> all outputs 0. Release, with no pix_valid_i -> outputs stay 0.
- IMG_WIDTH=8, IMG_HEIGHT=6, one frame continuous, pixel=row*8+col -> exactly 8 strobes.
  - First strobe follows pixel (4,4): centre (2,2), centre tap 18, tap(0,0)=0, tap(4,4)=36.
  - Last strobe follows (7,5): centre (5,3), centre tap 29.
- Same frame with random pix_valid_i bubbles (~50%) -> identical 8 windows in the same order. win_data_o holds during bubbles.
- Two back-to-back frames, sof only on the first -> 16 strobes. The second set is identical to the first.
- With macro: sof at (3,2) mid-frame -> frame_err_o one-cycle pulse, and windows restart correctly from the new frame. Without macro: same stimulus, frame_err_o stays 0.
- rst_n pulsed at (5,3) mid-frame, then a fresh full frame -> exactly 8 correct windows and no stale strobe.
